seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed N-digit seven-segment driver; next generation of the single-digit decimal LUT decoder.
- Decodes full hex (0-F) per digit and scans digits through a shared segment bus with a programmable refresh prescaler.
- Applies per-digit blanking and leading-zero suppression, and double-buffers the displayed value so updates only take effect at frame boundaries (no tearing).
- Sits between the UART receive datapath / status logic and the board's multiplexed display pins.

---
 rtl/seg7_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver : N-digit multiplexed hex seven-segment driver with
// frame-synchronous double buffering. Optional macro: SEG7_DP_EN.
// Revision: 1.0
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
`ifdef SEG7_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp
`endif
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_DIGITS - 1);
  localparam logic             c_inv      = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [NUM_DIGITS-1:0]   r_pend_mask;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [NUM_DIGITS-1:0]   r_disp_mask;
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
`endif

  logic                    w_tick;
  logic                    w_boundary;
  logic                    w_dead;
  logic                    w_dark;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg_act;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS:0]     w_upper_zero;

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    case (n)
      4'h0: f_decode = 7'b0111111;
      4'h1: f_decode = 7'b0000110;
      4'h2: f_decode = 7'b1011011;
      4'h3: f_decode = 7'b1001111;
      4'h4: f_decode = 7'b1100110;
      4'h5: f_decode = 7'b1101101;
      4'h6: f_decode = 7'b1111101;
      4'h7: f_decode = 7'b0000111;
      4'h8: f_decode = 7'b1111111;
      4'h9: f_decode = 7'b1101111;
      4'hA: f_decode = 7'b1110111;
      4'hB: f_decode = 7'b1111100;
      4'hC: f_decode = 7'b0111001;
      4'hD: f_decode = 7'b1011110;
      4'hE: f_decode = 7'b1111001;
      default: f_decode = 7'b1110001;
    endcase
  endfunction

  // w_upper_zero[i] is set when every displayed nibble from the top down to i is zero
  assign w_upper_zero[NUM_DIGITS] = 1'b1;
  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
      assign w_upper_zero[i] = w_upper_zero[i+1] & (r_disp[4*i +: 4] == 4'h0);
    end
  endgenerate

  always_comb begin
    w_tick     = (r_cnt == c_last_cnt);
    w_boundary = w_tick && (r_idx == c_last_idx);
    w_dead     = (r_cnt == '0);
    w_nib      = r_disp[{r_idx, 2'b00} +: 4];
    w_dark     = r_disp_mask[r_idx] |
                 (lz_blank_en & (r_idx != '0) & w_upper_zero[r_idx]);
    w_seg_act  = w_dark ? 7'd0 : f_decode(w_nib);
    w_onehot   = NUM_DIGITS'(1) << r_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pend       <= '0;
      r_pend_mask  <= '0;
      r_pend_valid <= 1'b0;
      r_disp       <= '0;
      r_disp_mask  <= '0;
      frame_done   <= 1'b0;
      seg          <= {7{c_inv}};
      dig_sel      <= {NUM_DIGITS{c_inv}};
`ifdef SEG7_DP_EN
      r_pend_dp    <= '0;
      r_disp_dp    <= '0;
      dp           <= c_inv;
`endif
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
      frame_done <= w_boundary;
      if (w_tick) begin
        r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
      end

      if (load) begin
        r_pend      <= value;
        r_pend_mask <= blank_mask;
`ifdef SEG7_DP_EN
        r_pend_dp   <= dp_in;
`endif
      end

      // A load landing on the boundary goes straight to the display buffer
      if (w_boundary) begin
        r_pend_valid <= 1'b0;
        if (load) begin
          r_disp      <= value;
          r_disp_mask <= blank_mask;
`ifdef SEG7_DP_EN
          r_disp_dp   <= dp_in;
`endif
        end else if (r_pend_valid) begin
          r_disp      <= r_pend;
          r_disp_mask <= r_pend_mask;
`ifdef SEG7_DP_EN
          r_disp_dp   <= r_pend_dp;
`endif
        end
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end

      seg     <= (w_dead ? 7'd0 : w_seg_act) ^ {7{c_inv}};
      dig_sel <= (w_dead ? '0 : w_onehot) ^ {NUM_DIGITS{c_inv}};
`ifdef SEG7_DP_EN
      dp      <= ((w_dead | r_disp_mask[r_idx]) ? 1'b0 : r_disp_dp[r_idx]) ^ c_inv;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_seg7_scan_driver : directed bench for seg7_scan_driver (4 digits,
// prescale 4, active-low pins). Revision: 1.0
// ============================================================================
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        lz_blank_en;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int total;
  int bad;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .PRESCALE   (4),
    .ACTIVE_LOW (1)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .blank_mask  (blank_mask),
    .lz_blank_en (lz_blank_en),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle load strobe starting at the current negedge
  task automatic do_load(input logic [15:0] v, input logic [3:0] m);
    load       = 1'b1;
    value      = v;
    blank_mask = m;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check({tag, "_fd_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Called at the negedge right after a frame boundary; e = {d3,d2,d1,d0} active-high segs
  task automatic scan_frame(input string tag, input logic [27:0] e);
    logic [3:0] sel;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      check({tag, "_dead_seg"}, {25'd0, seg}, 32'h7F);
      check({tag, "_dead_sel"}, {28'd0, dig_sel}, 32'hF);
      sel = ~(4'b0001 << d);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check({tag, "_seg"}, {25'd0, seg}, {25'd0, ~e[7*d +: 7]});
        check({tag, "_sel"}, {28'd0, dig_sel}, {28'd0, sel});
      end
    end
    check({tag, "_fd_end"}, {31'd0, frame_done}, 32'd1);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    load        = 1'b0;
    value       = 16'h0;
    blank_mask  = 4'h0;
    lz_blank_en = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_sel", {28'd0, dig_sel}, 32'hF);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    // Reach cnt=2, idx=2 (10 edges after release) then assert reset asynchronously
    repeat (10) @(posedge clk);
    #2;
    check("pre_rst_sel", {28'd0, dig_sel}, 32'hB);
    rst = 1'b1;
    #1;
    check("async_rst_seg", {25'd0, seg}, 32'h7F);
    check("async_rst_sel", {28'd0, dig_sel}, 32'hF);
    check("async_rst_fd", {31'd0, frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    check("held_rst_seg", {25'd0, seg}, 32'h7F);
    check("held_rst_sel", {28'd0, dig_sel}, 32'hF);
    rst = 1'b0;

    // First frame_done pulse lands 16 clocks after release
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("fd_timing", {31'd0, frame_done}, (k == 16) ? 32'd1 : 32'd0);
    end

    // Hex decode across all four slots
    do_load(16'h3A5F, 4'h0);
    wait_fd("hex_wait");
    scan_frame("hex", {7'b1001111, 7'b1110111, 7'b1101101, 7'b1110001});

    // Two loads within one frame: current frame untouched, last load wins
    do_load(16'h1111, 4'h0);
    @(negedge clk);
    do_load(16'h2222, 4'h0);
    check("tear_d0_seg", {25'd0, seg}, {25'd0, ~7'b1110001});
    check("tear_d0_sel", {28'd0, dig_sel}, 32'hE);
    repeat (4) @(negedge clk);
    check("tear_d1_seg", {25'd0, seg}, {25'd0, ~7'b1101101});
    check("tear_d1_sel", {28'd0, dig_sel}, 32'hD);
    wait_fd("tear_wait");
    scan_frame("tear", {4{7'b1011011}});

    // Load on the boundary cycle itself bypasses the pending buffer
    lz_blank_en = 1'b1;
    repeat (15) @(negedge clk);
    do_load(16'h00C0, 4'h0);
    scan_frame("bypass", {7'd0, 7'd0, 7'b0111001, 7'b0111111});

    // All zeros with suppression: only digit 0 stays lit
    do_load(16'h0000, 4'h0);
    wait_fd("lz_wait");
    scan_frame("lz_zero", {7'd0, 7'd0, 7'd0, 7'b0111111});

    // Mask blanks digit 0 explicitly
    do_load(16'h1234, 4'b0001);
    wait_fd("mask_wait");
    scan_frame("mask", {7'b0000110, 7'b1011011, 7'b1001111, 7'd0});

    // Suppression disabled: leading zeros shown again
    lz_blank_en = 1'b0;
    do_load(16'h00C0, 4'h0);
    wait_fd("nolz_wait");
    scan_frame("nolz", {7'b0111111, 7'b0111111, 7'b0111001, 7'b0111111});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
